// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode encodings and FSM state type shared by the alu_mc slice
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_if.sv
// ============================================================================
// alu_if : request/result handshake bundle between an ALU client and alu_mc
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_if #(
  parameter int DW = 32
);
  logic          i_valid;
  logic          o_ready;
  logic [3:0]    i_func;
  logic [DW-1:0] i_data_a;
  logic [DW-1:0] i_data_b;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data_y;
  logic          o_data_c;
  logic          o_data_z;
  logic          o_data_n;
  logic          o_data_v;
  logic          o_illegal;

  modport slave (
    input  i_valid, i_func, i_data_a, i_data_b, i_ready,
    output o_ready, o_valid, o_data_y, o_data_c, o_data_z, o_data_n, o_data_v, o_illegal
  );

  modport master (
    output i_valid, i_func, i_data_a, i_data_b, i_ready,
    input  o_ready, o_valid, o_data_y, o_data_c, o_data_z, o_data_n, o_data_v, o_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_mul.sv
// ============================================================================
// alu_mul : iterative shift-add unsigned multiplier, one partial product/cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_mul #(
  parameter int DW  = 32,
  parameter int CYC = DW
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_start,
  input  logic [DW-1:0]   i_a,
  input  logic [DW-1:0]   i_b,
  output logic            o_done,
  output logic [2*DW-1:0] o_prod
);

  localparam int CW = $clog2(CYC + 1);

  logic [2*DW-1:0] r_acc;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [2*DW-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Done and product are presented during the final iteration so the parent
  // can register the finished product on the same edge.
  assign o_done = (r_cnt == CW'(1));
  assign o_prod = w_acc_nxt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {{DW{1'b0}}, i_a};
      r_mplier <= i_b;
      r_cnt    <= CW'(CYC);
    end else if (r_cnt != '0) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_mc.sv
// ============================================================================
// alu_mc : multi-cycle ALU with valid/ready handshake; define ALU_MUL_EN to
//          build the iterative MUL path (otherwise MUL is reported illegal)
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_mc
  import alu_pkg::*;
#(
  parameter int DW      = 32,
  parameter int MUL_CYC = DW
) (
  input  logic i_clk,
  input  logic i_rstn,
  alu_if.slave bus
);

  localparam int SHW = $clog2(DW);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_mul_done;
  logic [2*DW-1:0] w_prod;
  logic [DW:0]     w_sum;
  logic [DW:0]     w_dif;
  logic [SHW-1:0]  w_sh;
  logic [DW-1:0]   w_res;
  logic            w_c, w_v, w_ill;
  logic            w_load;
  logic [DW-1:0]   w_ld_y;
  logic            w_ld_c, w_ld_v, w_ld_ill;
  logic [DW-1:0]   r_y;
  logic            r_c, r_z, r_n, r_v, r_ill;

  assign bus.o_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.i_ready);
  assign bus.o_valid   = (r_state == ST_DONE);
  assign bus.o_data_y  = r_y;
  assign bus.o_data_c  = r_c;
  assign bus.o_data_z  = r_z;
  assign bus.o_data_n  = r_n;
  assign bus.o_data_v  = r_v;
  assign bus.o_illegal = r_ill;

  assign w_accept = bus.i_valid && bus.o_ready;
  assign w_sh     = bus.i_data_b[SHW-1:0];
  assign w_sum    = {1'b0, bus.i_data_a} + {1'b0, bus.i_data_b};
  // Carry out of a + ~b + 1 is the "no borrow" flag.
  assign w_dif    = {1'b0, bus.i_data_a} + {1'b0, ~bus.i_data_b} + (DW+1)'(1);

`ifdef ALU_MUL_EN
  alu_mul #(
    .DW  (DW),
    .CYC (MUL_CYC)
  ) u_mul (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_start (w_accept && w_is_mul),
    .i_a     (bus.i_data_a),
    .i_b     (bus.i_data_b),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );
`else
  assign w_mul_done = 1'b0;
  assign w_prod     = '0;
`endif

  always_comb begin
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_ill    = 1'b0;
    w_is_mul = 1'b0;
    case (bus.i_func)
      OP_ADD: begin
        w_res = w_sum[DW-1:0];
        w_c   = w_sum[DW];
        w_v   = (bus.i_data_a[DW-1] == bus.i_data_b[DW-1]) && (w_sum[DW-1] != bus.i_data_a[DW-1]);
      end
      OP_SUB: begin
        w_res = w_dif[DW-1:0];
        w_c   = w_dif[DW];
        w_v   = (bus.i_data_a[DW-1] != bus.i_data_b[DW-1]) && (w_dif[DW-1] != bus.i_data_a[DW-1]);
      end
      OP_AND:  w_res = bus.i_data_a & bus.i_data_b;
      OP_OR:   w_res = bus.i_data_a | bus.i_data_b;
      OP_XOR:  w_res = bus.i_data_a ^ bus.i_data_b;
      OP_NOR:  w_res = ~(bus.i_data_a | bus.i_data_b);
      OP_SLT:  w_res = {{(DW-1){1'b0}}, $signed(bus.i_data_a) < $signed(bus.i_data_b)};
      OP_SLTU: w_res = {{(DW-1){1'b0}}, bus.i_data_a < bus.i_data_b};
      OP_SLL:  w_res = bus.i_data_a << w_sh;
      OP_SRL:  w_res = bus.i_data_a >> w_sh;
      OP_SRA:  w_res = $signed(bus.i_data_a) >>> w_sh;
`ifdef ALU_MUL_EN
      OP_MUL:  w_is_mul = 1'b1;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // Result registers load either at accept (single-cycle ops) or at the
  // multiplier's final iteration.
  always_comb begin
    w_load   = w_accept && !w_is_mul;
    w_ld_y   = w_res;
    w_ld_c   = w_c;
    w_ld_v   = w_v;
    w_ld_ill = w_ill;
    if (r_state == ST_BUSY) begin
      w_load   = w_mul_done;
      w_ld_y   = w_prod[DW-1:0];
      w_ld_c   = |w_prod[2*DW-1:DW];
      w_ld_v   = 1'b0;
      w_ld_ill = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
      ST_BUSY: if (w_mul_done) w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (bus.i_ready) begin
          if (w_accept) w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
          else          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_y     <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_y   <= w_ld_y;
        r_c   <= w_ld_c;
        r_z   <= (w_ld_y == '0);
        r_n   <= w_ld_y[DW-1];
        r_v   <= w_ld_v;
        r_ill <= w_ld_ill;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// tb_alu_mc : randomized self-checking bench for alu_mc against an arithmetic
//             reference model (honours ALU_MUL_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_mc;
  import alu_pkg::*;

  localparam int DW = 32;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  alu_if #(.DW(DW)) bus();

  alu_mc #(.DW(DW)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {illegal, v, n, z, c, y}
  function automatic logic [63:0] obs();
    return 64'({bus.o_illegal, bus.o_data_v, bus.o_data_n, bus.o_data_z, bus.o_data_c, bus.o_data_y});
  endfunction

  function automatic logic [63:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0]     y;
    logic            c, v, ill;
    longint          sa, sb, r;
    logic [63:0]     wide;
    int              sh;
    y   = 32'd0;
    c   = 1'b0;
    v   = 1'b0;
    ill = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sh  = int'(b % 32);
    case (f)
      OP_ADD: begin
        wide = 64'(a) + 64'(b);
        y = wide[31:0];
        c = (wide > 64'hFFFF_FFFF);
        r = sa + sb;
        v = (r > SMAX) || (r < SMIN);
      end
      OP_SUB: begin
        y = a - b;
        c = (a >= b);
        r = sa - sb;
        v = (r > SMAX) || (r < SMIN);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SLT:  y = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: y = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  y = a << sh;
      OP_SRL:  y = a >> sh;
      OP_SRA:  y = 32'(sa >>> sh);
      OP_MUL: begin
        if (MUL_EN) begin
          wide = 64'(a) * 64'(b);
          y = wide[31:0];
          c = (wide[63:32] != 32'd0);
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    return 64'({ill, v, y[31], (y == 32'd0), c, y});
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] edge_vals [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [63:0] exp;
    int          lat;
    int          edges;
    logic        rdy_seen;
    exp = model(f, a, b);
    lat = (f == OP_MUL && MUL_EN) ? 33 : 1;
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_func   = f;
    bus.i_data_a = a;
    bus.i_data_b = b;
    bus.i_ready  = 1'b0;
    chk("ready_idle", 64'(bus.o_ready), 64'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after accept; the captured operation must be unaffected.
    bus.i_valid  = 1'b0;
    bus.i_func   = 4'($urandom);
    bus.i_data_a = $urandom;
    bus.i_data_b = $urandom;
    edges    = 1;
    rdy_seen = 1'b0;
    while (!bus.o_valid && edges < 100) begin
      rdy_seen |= bus.o_ready;
      @(posedge clk);
      #1;
      edges++;
    end
    chk("latency", 64'(edges), 64'(lat));
    chk("result", obs(), exp);
    for (int i = 0; i < hold; i++) begin
      rdy_seen |= bus.o_ready;
      @(posedge clk);
      #1;
      chk("hold", obs() | (64'(bus.o_valid) << 40), exp | (64'd1 << 40));
    end
    rdy_seen |= bus.o_ready;
    chk("ready_wait", 64'(rdy_seen), 64'd0);
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    chk("drain", 64'(bus.o_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] q [8];
    logic [3:0]  f;
    logic [31:0] a, b;
    int          spur;

    bus.i_valid  = 1'b0;
    bus.i_ready  = 1'b0;
    bus.i_func   = 4'd0;
    bus.i_data_a = 32'd0;
    bus.i_data_b = 32'd0;

    repeat (3) @(negedge clk);
    chk("reset_out", obs(), 64'd0);
    chk("reset_valid", 64'(bus.o_valid), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(bus.o_ready), 64'd1);
    chk("reset_idle_valid", 64'(bus.o_valid), 64'd0);

    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    run_op(OP_SUB, 32'h1111_1111, 32'hAAAA_AAAA, 0);
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5);
    run_op(4'hF,   32'h1234_5678, 32'h9ABC_DEF0, 1);
    run_op(OP_SRA, 32'h8000_0000, 32'h0000_0021, 0);
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 0);

    repeat (40) run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), $urandom_range(0, 2));

    // Streaming: one single-cycle op per clock with both sides always ready.
    @(negedge clk);
    bus.i_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("stream_valid", 64'(bus.o_valid), 64'd1);
        chk("stream_y", obs(), q[i-1]);
      end
      chk("stream_ready", 64'(bus.o_ready), 64'd1);
      if (i < 8) begin
        do f = 4'($urandom_range(0, 15)); while (f == OP_MUL);
        a = pick_operand();
        b = pick_operand();
        q[i] = model(f, a, b);
        bus.i_valid  = 1'b1;
        bus.i_func   = f;
        bus.i_data_a = a;
        bus.i_data_b = b;
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("stream_end", 64'(bus.o_valid), 64'd0);
    bus.i_ready = 1'b0;

    // Reset pulse in the middle of a multiply.
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_func   = OP_MUL;
    bus.i_data_a = 32'hDEAD_BEEF;
    bus.i_data_b = 32'h0000_0003;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_mid_out", obs(), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 64'(bus.o_ready), 64'd1);
    spur = 0;
    repeat (40) begin
      @(negedge clk);
      spur += int'(bus.o_valid);
    end
    chk("no_spurious", 64'(spur), 64'd0);

    run_op(OP_XOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter MUL_CYC, default DW, multiplier iterations (fixed = DW; exposed read-only for benches).
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  operation request.
REQ-006 o_ready  output  1  block can accept a request.
REQ-007 i_func  input  4  opcode (ADD,SUB,AND,OR,XOR,NOR,SLT,SLTU,SLL,SRL,SRA,MUL; others illegal).
REQ-008 i_data_a, i_data_b  input  DW each  operands.
REQ-009 o_valid  output  1  result held and valid.
REQ-010 i_ready  input  1  consumer accepts result.
REQ-011 o_data_y  output  DW  result (MUL: low DW bits of product).
REQ-012 o_data_c, o_data_z, o_data_n, o_data_v  output  1 each  carry, zero, negative, signed-overflow flags.
REQ-013 o_illegal  output  1  opcode illegal or not compiled in.

Function
REQ-014 SHALL use FSM IDLE, BUSY, DONE; request accepted when i_valid && o_ready.
REQ-015 o_ready SHALL be 1 in IDLE, and in DONE only when i_ready=1 (back-to-back issue), 0 in BUSY.
REQ-016 Non-MUL ops SHALL register result: accept at edge k -> o_valid=1 after edge k (latency 1), state DONE.
REQ-017 MUL SHALL go IDLE->BUSY, run shift-add for MUL_CYC cycles, then DONE; o_valid after MUL_CYC+1 edges from accept.
REQ-018 DONE SHALL hold o_data_* and o_valid stable until i_ready=1; then ->IDLE, or directly restart if a new request is accepted same cycle.
REQ-019 ADD/SUB SHALL compute DW+1-bit result; o_data_c = bit DW (SUB: c=1 means no borrow, i.e. a>=b unsigned).
REQ-020 o_data_v SHALL be signed overflow for ADD/SUB, 0 for all other ops.
REQ-021 SLT/SLTU SHALL yield 1 or 0 zero-extended; shifts SHALL use i_data_b[$clog2(DW)-1:0] only.
REQ-022 o_data_z = (o_data_y==0), o_data_n = o_data_y[DW-1] for every op; MUL c=1 iff upper product half nonzero.
REQ-023 Illegal opcode SHALL complete in 1 cycle with y=0, all flags 0 except z=1, o_illegal=1.
REQ-024 Operands SHALL be captured at accept; input changes during BUSY/DONE SHALL not affect result.

Reset
REQ-025 On i_rstn=0 SHALL immediately force state IDLE, o_valid=0, o_ready=1 after release, o_data_y=0, all flags 0, o_illegal=0.
REQ-026 Reset during BUSY SHALL abort the multiply with no result produced.

Configuration
REQ-027 Macro ALU_MUL_EN defined: MUL implemented per REQ-017.
REQ-028 Macro ALU_MUL_EN undefined: no multiplier logic; MUL treated as illegal per REQ-023.

Structure
REQ-029 Opcode localparams and FSM state encodings SHALL live in shared package alu_pkg.
REQ-030 Iterative multiplier SHALL be sub-module alu_mul (start/done handshake, DW parameter), instantiated only under ALU_MUL_EN.

Verification (DW=32)
REQ-031 ADD 0xFFFF_FFFF+0x0000_0001 -> y=0, c=1, z=1, v=0, one cycle latency.
REQ-032 ADD 0x7FFF_FFFF+1 -> y=0x8000_0000, n=1, v=1; SUB 0x1111_1111-0xAAAA_AAAA -> y=0x6666_6667, c=0.
REQ-033 MUL 0x0001_0000*0x0001_0000 -> y=0, c=1, o_valid after 33 edges, o_ready=0 throughout BUSY.
REQ-034 i_ready held 0 for 5 cycles in DONE -> outputs stable; then streaming 8 ops with i_valid=i_ready=1 -> one result per cycle.
REQ-035 i_func=4'hF -> o_illegal=1, y=0, z=1; without ALU_MUL_EN, MUL -> same response.
REQ-036 i_rstn pulsed low mid-MUL -> o_valid=0, o_ready=1 after release, no spurious result.
